sfp_xchg_ctrl: RTL

- Per-core controller that sequences the exchange of SFP partial sums between the two cores of the dual-core chip.
- It latches the local core's sum and offers it to the partner core with a 4-phase req/ack handshake. It accepts the partner's sum through the same protocol and issues the combined normalisation total back to the core.
- One instance sits inside each core's clock domain. The cross-domain req/ack/data lines pass through the existing 2-flop `sync` blocks.

---
 rtl/sfp_xchg_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sfp_xchg_ctrl.sv
// -----------------------------------------------------------------------------
// sfp_xchg_ctrl
//
// Per-core controller that swaps SFP partial sums with the partner core of a
// dual-core chip and hands the combined normalisation total back to the core.
//
// There are two independent halves:
//   * Sender: latches the local sum and offers it to the partner with a
//     4-phase req/ack handshake (req up, ack up, req down, ack down).
//   * Receiver: answers the partner's 4-phase handshake. It captures the
//     partner's sum one cycle after seeing req, so the bits that crossed
//     through the 2-flop synchronisers have settled.
// When both halves have finished (S_DONE and R_DONE), the controller registers
// local + remote, pulses sum_total_valid for one cycle, bumps xchg_cnt, and
// returns both halves to IDLE in the same cycle. Either half may finish first;
// the finished half waits in its DONE state.
//
// Handshake semantics (both directions):
//   The sender raises req only after its data is latched, and the data does
//   not change while req is high. The receiver raises ack only after it has
//   captured the data. The sender drops req only after it sees ack. The
//   receiver drops ack only after it sees req low. A new offer may start only
//   after the sender has seen ack low.
//
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   sum_local_in/valid local SFP sum with one-cycle strobe
//   sfp_sum_out        held local sum towards the partner (via sync)
//   req_out / ack_in   sender side of the handshake
//   sfp_sum_in         partner sum (already synchronised)
//   req_in / ack_out   receiver side of the handshake
//   sum_total/_valid   local + remote total, one-cycle strobe
//   busy               some half of the exchange is not idle
//   overrun            sticky: local strobe arrived while sender was busy
//   xchg_cnt           completed exchanges, wraps
//   sender_state       sender FSM state (debug observation)
//   receiver_state     receiver FSM state (debug observation)
// -----------------------------------------------------------------------------
module sfp_xchg_ctrl #(
    parameter int bw_psum = 20,
    parameter int cnt_bw  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [bw_psum+3:0]   sum_local_in,
    input  logic                 sum_local_valid,
    output logic [bw_psum+3:0]   sfp_sum_out,
    output logic                 req_out,
    input  logic                 ack_in,
    input  logic [bw_psum+3:0]   sfp_sum_in,
    input  logic                 req_in,
    output logic                 ack_out,
    output logic [bw_psum+4:0]   sum_total,
    output logic                 sum_total_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [cnt_bw-1:0]    xchg_cnt,
    output logic [1:0]           sender_state,
    output logic [1:0]           receiver_state
);

    localparam int SW = bw_psum + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2,
        S_DONE = 2'd3
    } s_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_SETTLE = 2'd1,
        R_ACK    = 2'd2,
        R_DONE   = 2'd3
    } r_state_t;

    s_state_t        s_state;
    r_state_t        r_state;
    logic [SW-1:0]   remote_sum;
    logic            complete;

    // Both halves have finished their handshakes this cycle.
    assign complete = (s_state == S_DONE) && (r_state == R_DONE);

    assign sender_state   = s_state;
    assign receiver_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_state         <= S_IDLE;
            r_state         <= R_IDLE;
            sfp_sum_out     <= '0;
            req_out         <= 1'b0;
            ack_out         <= 1'b0;
            remote_sum      <= '0;
            sum_total       <= '0;
            sum_total_valid <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
            xchg_cnt        <= '0;
        end else begin
            sum_total_valid <= 1'b0;

            // busy tracks the states being entered at this edge, so it
            // reads high from the same cycle a half leaves IDLE and drops
            // together with the completion. Completion is the only way
            // back to IDLE outside reset.
            busy <= !complete &&
                    ((s_state != S_IDLE) || (r_state != R_IDLE) ||
                     sum_local_valid || req_in);

            // A strobe the sender cannot take is dropped; the held value
            // is left alone and the error is remembered until reset.
            if (sum_local_valid && (s_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            if (complete) begin
                sum_total       <= {1'b0, sfp_sum_out} + {1'b0, remote_sum};
                sum_total_valid <= 1'b1;
                xchg_cnt        <= xchg_cnt + 1'b1;
                s_state         <= S_IDLE;
                r_state         <= R_IDLE;
            end else begin
                // ---------------- sender ----------------
                case (s_state)
                    S_IDLE: begin
                        if (sum_local_valid) begin
                            sfp_sum_out <= sum_local_in;
                            req_out     <= 1'b1;
                            s_state     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (ack_in) begin
                            req_out <= 1'b0;
                            s_state <= S_REL;
                        end
                    end
                    S_REL: begin
                        if (!ack_in) begin
                            s_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // Wait for the receiver half to finish.
                    end
                    default: s_state <= S_IDLE;
                endcase

                // ---------------- receiver ----------------
                case (r_state)
                    R_IDLE: begin
                        if (req_in) begin
                            r_state <= R_SETTLE;
                        end
                    end
                    R_SETTLE: begin
                        // One cycle after req was seen the synchronised data
                        // bits have had time to settle.
                        remote_sum <= sfp_sum_in;
                        ack_out    <= 1'b1;
                        r_state    <= R_ACK;
                    end
                    R_ACK: begin
                        if (!req_in) begin
                            ack_out <= 1'b0;
                            r_state <= R_DONE;
                        end
                    end
                    R_DONE: begin
                        // req_in is ignored here: one acceptance per exchange.
                    end
                    default: r_state <= R_IDLE;
                endcase
            end
        end
    end

endmodule
